// File: rtl/pending_encoder_32x5_pkg.sv
// pending_encoder_32x5_pkg
// Shared constants and types for the 32-line pending-request encoder.
//   N        : number of request lines (32)
//   ID_W     : width of a source index (5)
//   state_e  : offer FSM encoding (StIdle = 0, StOffer = 1)
//   LAST_RST : reset value of the round-robin pointer, so the first scan starts at 0
package pending_encoder_32x5_pkg;

    localparam int unsigned N    = 32;
    localparam int unsigned ID_W = 5;

    typedef enum logic {
        StIdle  = 1'b0,
        StOffer = 1'b1
    } state_e;

    localparam logic [ID_W-1:0] LAST_RST = 5'd31;

endpackage

// File: rtl/pending_encoder_32x5_if.sv
// pending_encoder_32x5_if
// Request/offer bus between the request sources plus consumer (master) and the
// encoder (slave).
//   req     : one-cycle request pulses, bit i sets pending bit i
//   mask    : per-source eligibility, 1 = may be selected
//   ack     : consumer accepts the offered id (ignored while valid = 0)
//   valid   : id holds a selected pending source
//   id      : index of the offered source
//   pending : raw pending register, unmasked
interface pending_encoder_32x5_if;
    import pending_encoder_32x5_pkg::*;

    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            ack;
    logic            valid;
    logic [ID_W-1:0] id;
    logic [N-1:0]    pending;

    modport master (
        output req,
        output mask,
        output ack,
        input  valid,
        input  id,
        input  pending
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        output valid,
        output id,
        output pending
    );

endinterface

// File: rtl/pending_encoder_32x5_penc.sv
// penc_32x5
// Combinational 32-to-5 priority encoder with a programmable scan start.
// Scans e circularly from index start upward and returns the first set index.
//   e     : candidate vector
//   start : first index examined (0 gives fixed priority, index 0 highest)
//   idx   : selected index (0 when any = 0)
//   any   : at least one bit of e is set
module penc_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic [N-1:0]    e,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] k;

    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            // 5-bit addition wraps modulo 32, giving the circular scan
            k = start + ID_W'(i);
            if (!any && e[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

endmodule

// File: rtl/pending_encoder_32x5.sv
// pending_encoder_32x5
// Sequential 32-line to 5-bit priority encoder. Request pulses accumulate in a
// pending register; one eligible source (pending & mask) is offered as a 5-bit
// id under a valid/ack handshake. Each accepted id clears its pending bit, and
// a new id can be offered on the same edge for back-to-back grants.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : pending_encoder_32x5_if.slave (req, mask, ack in; valid, id, pending out)
// Optional feature: define PENC_ROUND_ROBIN_EN for round-robin selection starting
// after the last accepted id; otherwise fixed priority with index 0 highest.
module pending_encoder_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    pending_encoder_32x5_if.slave bus
);

    state_e          state_q;
    logic [N-1:0]    p_q;
    logic [N-1:0]    p_d;
    logic [ID_W-1:0] id_q;
    logic            valid_q;

    logic            hs;
    logic [N-1:0]    id_onehot;
    logic [N-1:0]    clr;
    logic [N-1:0]    e;
    logic [N-1:0]    e_next;
    logic [N-1:0]    sel_in;
    logic [ID_W-1:0] start;
    logic [ID_W-1:0] sel_idx;
    logic            sel_any;

    assign hs        = valid_q & bus.ack;
    assign id_onehot = {{(N-1){1'b0}}, 1'b1} << id_q;
    assign clr       = hs ? id_onehot : '0;

    // A request on the bit being cleared wins, so the source is not lost
    assign p_d    = (p_q & ~clr) | bus.req;
    assign e      = p_q & bus.mask;
    // Candidates for a back-to-back grant: include this cycle's requests,
    // exclude the id being accepted
    assign e_next = (p_q | bus.req) & bus.mask & ~id_onehot;
    assign sel_in = (state_q == StOffer) ? e_next : e;

`ifdef PENC_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;

    // On a handshake the accepted id becomes the new last, so scan after it
    assign start = (state_q == StOffer) ? id_q + 1'b1 : last_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_RST;
        end else if (hs) begin
            last_q <= id_q;
        end
    end
`else
    assign start = '0;
`endif

    penc_32x5 u_penc (
        .e     (sel_in),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_any) begin
                        id_q    <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= StOffer;
                    end
                end
                StOffer: begin
                    // Offer is frozen until accepted, regardless of mask or pending
                    if (bus.ack) begin
                        if (sel_any) begin
                            id_q <= sel_idx;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.id      = id_q;
    assign bus.pending = p_q;

endmodule
